glyph_rom_arbiter: RTL and testbench
====================================

# glyph_rom_arbiter

Shares the single-port, 1-cycle-latency glyph ROM between two readers: the VGA pixel pipeline (absolute priority, one read per cycle during active video) and a secondary requester, the CPU/sprite loader, which uses a req/ack handshake. It sits between the VGA renderer and the glyph ROM instance. It drives the ROM address, tags every issued read with its owner, and routes returned pixel data to the correct consumer. It also flags CPU starvation for software.

## Interface
- ADDR_W, 17, glyph ROM address width
- DATA_W, 24, glyph pixel width (RGB888)
- STARVE_MAX, 1024, consecutive denied CPU cycles before starve_flag sets
- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  reset, asynchronous, active-low
- vga_req  in  1  VGA read request this cycle
- vga_addr  in  ADDR_W  VGA glyph address
- vga_pixel  out  DATA_W  pixel returned to VGA
- vga_valid  out  1  vga_pixel valid strobe
- cpu_req  in  1  CPU read request, level
- cpu_addr  in  ADDR_W  CPU glyph address, stable while cpu_req high and cpu_ack low
- cpu_ack  out  1  CPU address accepted this cycle
- cpu_rdata  out  DATA_W  data returned to CPU
- cpu_rvalid  out  1  cpu_rdata valid strobe
- starve_clr  in  1  clears starve_flag
- starve_flag  out  1  sticky CPU starvation indicator
- rom_addr  out  ADDR_W  registered address to glyph ROM
- rom_data  in  DATA_W  ROM output, valid 1 cycle after rom_addr

## Operation
- Arbitration is combinational per cycle. vga_req wins. Otherwise cpu_req wins. Otherwise idle.
- Grant cycle: the winner's address is registered into rom_addr. If CPU wins, cpu_ack=1 combinationally in that same cycle.
- After an ack, the CPU may present a new address with cpu_req held high. Back-to-back CPU reads are allowed at one per cycle.
- Idle cycles: rom_addr holds its last value. The issued owner tag is OWN_NONE.
- Owner tag pipeline has 2 stages (OWN_NONE/OWN_VGA/OWN_CPU). Stage 1 is aligned with rom_addr. Stage 2 is aligned with rom_data.
- Stage 2 = OWN_VGA: vga_pixel<=rom_data and vga_valid<=1.
- Stage 2 = OWN_CPU: cpu_rdata<=rom_data and cpu_rvalid<=1.
- Strobes are 1-cycle pulses. Data outputs hold their last value otherwise.
- Starvation counter counts cycles with cpu_req=1 and cpu_ack=0. It clears to 0 on cpu_ack or cpu_req=0, and saturates at STARVE_MAX.
- When the counter reaches STARVE_MAX, starve_flag sets and stays set until starve_clr.
- If set and starve_clr occur in the same cycle, set wins.
- The CPU is never allowed to preempt VGA, because that would tear the displayed image. Starvation is reported only.
- The design holds no further state. No FSM beyond the tag pipeline and the counter.

## Timing
- Reset values: rom_addr=0, vga_pixel=0, vga_valid=0, cpu_rdata=0, cpu_rvalid=0, starve_flag=0, counter=0, both tag stages OWN_NONE.
- cpu_ack is combinational, so it is 0 whenever rst_n=0.
- Latency: a request granted in cycle N appears on vga_pixel/cpu_rdata with its strobe in cycle N+3. The stages are N+1 rom_addr, N+2 rom_data, N+3 output register.
- Throughput: 1 read/cycle total.
- Simultaneous vga_req and cpu_req: VGA granted, cpu_ack=0, counter increments.
- A reset asserted mid-flight discards in-flight reads. No strobe is emitted for reads granted before reset.
- cpu_req dropped before ack: nothing is issued and the counter clears.

## Structure
- Shared package glyph_pkg holds ADDR_W, DATA_W, and the owner enum (OWN_NONE, OWN_VGA, OWN_CPU). The VGA renderer reuses it.
- The glyph ROM stays outside this block and is instantiated alongside it at the top level.
- One natural sub-module: glyph_starve_mon (counter, saturation, sticky flag, clear).

## Test plan
- Only VGA: vga_req=1 for 4 cycles with addrs 0x10..0x13 → vga_valid high for 4 cycles starting 3 cycles later, vga_pixel = rom[0x10..0x13] in order, cpu_rvalid never pulses.
- Only CPU, back-to-back: cpu_req=1 with addrs 0x20,0x21 → cpu_ack in 2 consecutive cycles, cpu_rvalid 3 cycles after each ack, cpu_rdata = rom[0x20], rom[0x21].
- Contention: cpu_req=1 held, VGA requests for 5 cycles then stops → no cpu_ack for 5 cycles, ack in cycle 6, CPU data never appears on vga_pixel.
- Starvation with STARVE_MAX=8: VGA continuous, cpu_req held → starve_flag=1 after 8 denied cycles, stays set after cpu_ack. starve_clr pulse → 0. starve_clr on the set cycle → remains 1.
- Reset mid-flight: VGA read to 0x30 granted, rst_n low for 1 cycle at N+1 → no vga_valid at N+3, all outputs at reset values.

Source files
------------

// File: rtl/glyph_rom_arbiter_pkg.sv
// glyph_pkg: shared widths and read-owner tags for the glyph ROM path.
// Imported by the arbiter, its interface, and the VGA renderer.
package glyph_pkg;

   localparam int ADDR_W = 17;
   localparam int DATA_W = 24;

   // Owner of a ROM read as it travels down the tag pipeline
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_VGA  = 2'd1,
      OWN_CPU  = 2'd2
   } own_e;

endpackage

// File: rtl/glyph_rom_arbiter_if.sv
// glyph_rom_arbiter_if: VGA read port, CPU req/ack port, starvation
// status and the ROM address/data pair. slave = arbiter, master = env.
interface glyph_rom_arbiter_if;
   import glyph_pkg::*;

   logic              vga_req;
   logic [ADDR_W-1:0] vga_addr;
   logic [DATA_W-1:0] vga_pixel;
   logic              vga_valid;

   logic              cpu_req;
   logic [ADDR_W-1:0] cpu_addr;
   logic              cpu_ack;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_rvalid;

   logic              starve_clr;
   logic              starve_flag;

   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data;

   modport master (
      output vga_req, vga_addr, cpu_req, cpu_addr,
      output starve_clr, rom_data,
      input  vga_pixel, vga_valid, cpu_ack,
      input  cpu_rdata, cpu_rvalid, starve_flag, rom_addr
   );

   modport slave (
      input  vga_req, vga_addr, cpu_req, cpu_addr,
      input  starve_clr, rom_data,
      output vga_pixel, vga_valid, cpu_ack,
      output cpu_rdata, cpu_rvalid, starve_flag, rom_addr
   );

endinterface

// File: rtl/glyph_rom_arbiter_starve_mon.sv
// glyph_starve_mon: counts consecutive denied CPU cycles and raises a
// sticky flag. Ports: clk, rst_n, cpu_req, cpu_ack, starve_clr, starve_flag.
module glyph_starve_mon #(
   parameter int STARVE_MAX = 1024
) (
   input  logic clk,
   input  logic rst_n,
   input  logic cpu_req,
   input  logic cpu_ack,
   input  logic starve_clr,
   output logic starve_flag
);

   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
   localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(STARVE_MAX - 1);

   logic             denied;
   logic             set;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             flag_q, flag_d;

   always_comb begin
      denied = cpu_req & ~cpu_ack;
      // Set fires only on the step that reaches the limit, so a clear
      // while still saturated takes effect.
      set    = denied & (cnt_q == CNT_PRE);
      cnt_d  = '0;
      if (denied) begin
         cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      end
      flag_d = set | (flag_q & ~starve_clr);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         flag_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         flag_q <= flag_d;
      end
   end

   assign starve_flag = flag_q;

endmodule

// File: rtl/glyph_rom_arbiter.sv
// glyph_rom_arbiter: shares the 1-cycle glyph ROM between VGA (priority)
// and CPU (req/ack); tags reads and routes data back. Ports: clk, rst_n, bus.
module glyph_rom_arbiter
   import glyph_pkg::*;
#(
   parameter int STARVE_MAX = 1024
) (
   input logic                clk,
   input logic                rst_n,
   glyph_rom_arbiter_if.slave bus
);

   logic              vga_win;
   logic              cpu_win;
   own_e              iss_own;

   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   own_e              tag1_q, tag1_d;
   own_e              tag2_q, tag2_d;
   logic [DATA_W-1:0] vga_pixel_q, vga_pixel_d;
   logic              vga_valid_q, vga_valid_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic              cpu_rvalid_q, cpu_rvalid_d;

   // One-hot winner; ack gated by rst_n so it is low during reset
   always_comb begin
      vga_win    = bus.vga_req;
      cpu_win    = bus.cpu_req & ~bus.vga_req & rst_n;
      iss_own    = OWN_NONE;
      rom_addr_d = rom_addr_q;
      unique case (1'b1)
         vga_win: begin
            iss_own    = OWN_VGA;
            rom_addr_d = bus.vga_addr;
         end
         cpu_win: begin
            iss_own    = OWN_CPU;
            rom_addr_d = bus.cpu_addr;
         end
         default: ;
      endcase
   end

   // tag1 rides with rom_addr, tag2 with rom_data
   always_comb begin
      tag1_d       = iss_own;
      tag2_d       = tag1_q;
      vga_pixel_d  = vga_pixel_q;
      vga_valid_d  = 1'b0;
      cpu_rdata_d  = cpu_rdata_q;
      cpu_rvalid_d = 1'b0;
      if (tag2_q == OWN_VGA) begin
         vga_pixel_d = bus.rom_data;
         vga_valid_d = 1'b1;
      end
      if (tag2_q == OWN_CPU) begin
         cpu_rdata_d  = bus.rom_data;
         cpu_rvalid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rom_addr_q   <= '0;
         tag1_q       <= OWN_NONE;
         tag2_q       <= OWN_NONE;
         vga_pixel_q  <= '0;
         vga_valid_q  <= 1'b0;
         cpu_rdata_q  <= '0;
         cpu_rvalid_q <= 1'b0;
      end else begin
         rom_addr_q   <= rom_addr_d;
         tag1_q       <= tag1_d;
         tag2_q       <= tag2_d;
         vga_pixel_q  <= vga_pixel_d;
         vga_valid_q  <= vga_valid_d;
         cpu_rdata_q  <= cpu_rdata_d;
         cpu_rvalid_q <= cpu_rvalid_d;
      end
   end

   assign bus.cpu_ack    = cpu_win;
   assign bus.rom_addr   = rom_addr_q;
   assign bus.vga_pixel  = vga_pixel_q;
   assign bus.vga_valid  = vga_valid_q;
   assign bus.cpu_rdata  = cpu_rdata_q;
   assign bus.cpu_rvalid = cpu_rvalid_q;

   glyph_starve_mon #(
      .STARVE_MAX (STARVE_MAX)
   ) u_starve (
      .clk         (clk),
      .rst_n       (rst_n),
      .cpu_req     (bus.cpu_req),
      .cpu_ack     (cpu_win),
      .starve_clr  (bus.starve_clr),
      .starve_flag (bus.starve_flag)
   );

endmodule

// File: tb/tb_glyph_rom_arbiter.sv
// tb_glyph_rom_arbiter: directed tables plus random traffic checked
// against a cycle-scheduled reference of the arbiter.
module tb_glyph_rom_arbiter;
   import glyph_pkg::*;

   localparam int SMAX = 8;
   localparam int NCYC = 2048;

   typedef struct {
      bit              vr;
      logic [ADDR_W-1:0] va;
      bit              cr;
      logic [ADDR_W-1:0] ca;
      bit              clr;
      bit              e_ack;
      bit              e_vv;
      bit              e_cv;
      bit              e_flag;
   } row_t;

   logic clk;
   logic rst_n;
   glyph_rom_arbiter_if bus();

   glyph_rom_arbiter #(.STARVE_MAX(SMAX)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DATA_W-1:0] rom_f(logic [ADDR_W-1:0] a);
      return {a[7:0] ^ 8'hA5, ~a[15:0]};
   endfunction

   // Behavioural ROM: data one cycle after address
   always @(posedge clk) bus.rom_data <= rom_f(bus.rom_addr);

   int n_chk = 0;
   int n_err = 0;

   // Reference: each grant schedules its result 3 cycles ahead
   int                sched_own [NCYC];
   logic [DATA_W-1:0] sched_dat [NCYC];
   int                k;
   logic [DATA_W-1:0] m_pix, m_crd;
   logic [ADDR_W-1:0] m_raddr;
   int                m_cnt;
   bit                m_flag;
   bit                m_last_ack;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, k, act, exp);
      end
   endtask

   task automatic model_clear();
      for (int j = k; j < NCYC; j++) begin
         sched_own[j] = 0;
         sched_dat[j] = '0;
      end
      m_pix = '0; m_crd = '0; m_raddr = '0;
      m_cnt = 0; m_flag = 1'b0; m_last_ack = 1'b0;
   endtask

   task automatic cycle(input bit use_row, input row_t r);
      bit e_ack;
      bit denied;
      bit set;
      int own_now;
      @(negedge clk);
      own_now = sched_own[k];
      if (own_now == 1) m_pix = sched_dat[k];
      if (own_now == 2) m_crd = sched_dat[k];
      e_ack = rst_n && bus.cpu_req && !bus.vga_req;
      chk("cpu_ack", bus.cpu_ack, e_ack);
      chk("vga_valid", bus.vga_valid, own_now == 1);
      chk("cpu_rvalid", bus.cpu_rvalid, own_now == 2);
      chk("vga_pixel", bus.vga_pixel, m_pix);
      chk("cpu_rdata", bus.cpu_rdata, m_crd);
      chk("rom_addr", bus.rom_addr, m_raddr);
      chk("starve_flag", bus.starve_flag, m_flag);
      if (use_row) begin
         chk("row_ack", bus.cpu_ack, r.e_ack);
         chk("row_vvalid", bus.vga_valid, r.e_vv);
         chk("row_cvalid", bus.cpu_rvalid, r.e_cv);
         chk("row_flag", bus.starve_flag, r.e_flag);
      end
      if (rst_n) begin
         if (bus.vga_req) begin
            sched_own[k+3] = 1;
            sched_dat[k+3] = rom_f(bus.vga_addr);
            m_raddr = bus.vga_addr;
         end else if (bus.cpu_req) begin
            sched_own[k+3] = 2;
            sched_dat[k+3] = rom_f(bus.cpu_addr);
            m_raddr = bus.cpu_addr;
         end
         denied = bus.cpu_req && !e_ack;
         set = denied && (m_cnt == SMAX - 1);
         if (!denied) m_cnt = 0;
         else if (m_cnt < SMAX) m_cnt++;
         m_flag = set ? 1'b1 : (bus.starve_clr ? 1'b0 : m_flag);
      end
      m_last_ack = e_ack;
      k++;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input row_t r);
      bus.vga_req    = r.vr;
      bus.vga_addr   = r.va;
      bus.cpu_req    = r.cr;
      bus.cpu_addr   = r.ca;
      bus.starve_clr = r.clr;
   endtask

   function automatic row_t mk(bit vr, int va, bit cr, int ca, bit clr,
                               bit ack, bit vv, bit cv, bit fl);
      row_t r;
      r.vr = vr; r.va = ADDR_W'(va); r.cr = cr; r.ca = ADDR_W'(ca);
      r.clr = clr; r.e_ack = ack; r.e_vv = vv; r.e_cv = cv;
      r.e_flag = fl;
      return r;
   endfunction

   row_t tbl [23];
   row_t stv [25];
   row_t idle_r;

   initial begin
      // VGA only, then CPU back-to-back, then contention
      tbl[0]  = mk(1, 'h10, 0, 0,    0, 0, 0, 0, 0);
      tbl[1]  = mk(1, 'h11, 0, 0,    0, 0, 0, 0, 0);
      tbl[2]  = mk(1, 'h12, 0, 0,    0, 0, 0, 0, 0);
      tbl[3]  = mk(1, 'h13, 0, 0,    0, 0, 1, 0, 0);
      tbl[4]  = mk(0, 0,    0, 0,    0, 0, 1, 0, 0);
      tbl[5]  = mk(0, 0,    0, 0,    0, 0, 1, 0, 0);
      tbl[6]  = mk(0, 0,    0, 0,    0, 0, 1, 0, 0);
      tbl[7]  = mk(0, 0,    1, 'h20, 0, 1, 0, 0, 0);
      tbl[8]  = mk(0, 0,    1, 'h21, 0, 1, 0, 0, 0);
      tbl[9]  = mk(0, 0,    0, 0,    0, 0, 0, 0, 0);
      tbl[10] = mk(0, 0,    0, 0,    0, 0, 0, 1, 0);
      tbl[11] = mk(0, 0,    0, 0,    0, 0, 0, 1, 0);
      tbl[12] = mk(0, 0,    0, 0,    0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++)
         tbl[13+i] = mk(1, 'h50 + i, 1, 'h40, 0, 0, i >= 3, 0, 0);
      tbl[18] = mk(0, 0,    1, 'h40, 0, 1, 1, 0, 0);
      tbl[19] = mk(0, 0,    0, 0,    0, 0, 1, 0, 0);
      tbl[20] = mk(0, 0,    0, 0,    0, 0, 1, 0, 0);
      tbl[21] = mk(0, 0,    0, 0,    0, 0, 0, 1, 0);
      tbl[22] = mk(0, 0,    0, 0,    0, 0, 0, 0, 0);

      // Starvation: set, hold through ack, clear, then clear on set cycle
      for (int i = 0; i < 25; i++) begin
         bit vr, cr, clr, ack, vv, cv, fl;
         vr  = (i <= 9) || (i >= 14 && i <= 21);
         cr  = (i <= 10) || (i >= 14 && i <= 21);
         clr = (i == 12) || (i == 21) || (i == 23);
         ack = (i == 10);
         vv  = (i >= 3 && i <= 12) || (i >= 17);
         cv  = (i == 13);
         fl  = (i >= 8 && i <= 12) || (i >= 22 && i <= 23);
         stv[i] = mk(vr, 'h70 + i, cr, 'h60, clr, ack, vv, cv, fl);
      end
      idle_r = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Reset state, with cpu_req high to show ack is forced low
      k = 0;
      rst_n = 1'b0;
      drive(idle_r);
      bus.cpu_req = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ack", bus.cpu_ack, 0);
      chk("rst_rom_addr", bus.rom_addr, 0);
      chk("rst_vvalid", bus.vga_valid, 0);
      chk("rst_pixel", bus.vga_pixel, 0);
      chk("rst_cvalid", bus.cpu_rvalid, 0);
      chk("rst_rdata", bus.cpu_rdata, 0);
      chk("rst_flag", bus.starve_flag, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.cpu_req = 1'b0;
      model_clear();

      for (int i = 0; i < 23; i++) begin
         drive(tbl[i]);
         cycle(1'b1, tbl[i]);
      end
      for (int i = 0; i < 25; i++) begin
         drive(stv[i]);
         cycle(1'b1, stv[i]);
      end

      // Reset mid-flight: VGA read to 0x30, reset the next cycle
      drive(mk(1, 'h30, 0, 0, 0, 0, 0, 0, 0));
      cycle(1'b0, idle_r);
      rst_n = 1'b0;
      model_clear();
      drive(idle_r);
      bus.cpu_req = 1'b1;
      cycle(1'b0, idle_r);
      rst_n = 1'b1;
      drive(idle_r);
      cycle(1'b0, idle_r);
      @(negedge clk);
      chk("rst_no_strobe", bus.vga_valid, 0);
      chk("rst_no_pixel", bus.vga_pixel, 0);
      @(posedge clk);
      #1;
      // Keep the reference cycle index in step with the extra cycle
      k++;

      // Random traffic; CPU keeps its address until acked
      begin
         bit busy;
         busy = 1'b0;
         for (int i = 0; i < 400; i++) begin
            if ((i % 40) == 0) busy = ($urandom_range(0, 1) == 1);
            bus.vga_req  = busy ? ($urandom_range(0, 15) != 0)
                                : ($urandom_range(0, 1) == 1);
            bus.vga_addr = ADDR_W'($urandom);
            if (!bus.cpu_req || m_last_ack) begin
               bus.cpu_req  = ($urandom_range(0, 2) != 0);
               bus.cpu_addr = ADDR_W'($urandom);
            end else if ($urandom_range(0, 15) == 0) begin
               bus.cpu_req = 1'b0;
            end
            bus.starve_clr = ($urandom_range(0, 7) == 0);
            cycle(1'b0, idle_r);
         end
      end

      drive(idle_r);
      repeat (4) cycle(1'b0, idle_r);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
